ex_md_stage: RTL
================

Name: ex_md_stage

Overview:
- Execute (EX) stage that feeds the MEM stage through the EX/MEM pipeline register.
- Single-cycle ALU for logic, add/sub and shift ops.
- Iterative 32-cycle unsigned multiply/divide unit that holds the pipeline through `busy`.
- Forwards the in-flight result to ID and detects signed overflow.

Parameters:
- MD_CYCLES, 32, iterations per multiply/divide (one result bit per cycle; must equal data width)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-low
- stall  in  1  pipeline hold from controller
- flush  in  1  pipeline flush from controller
- busy  out  1  multi-cycle op in progress; controller stalls pipeline
- fwd_data  out  32  current ALU/MD result for forwarding
- id_pc  in  30  word PC
- id_en  in  1  ID/EX entry valid
- id_alu_op  in  4  ALU op
- id_alu_in_0  in  32  operand A
- id_alu_in_1  in  32  operand B
- id_br_flag  in  1  branch flag
- id_mem_op  in  2  memory op
- id_mem_wr_data  in  32  store data
- id_ctrl_op  in  2  control-register op
- id_dst_addr  in  5  GPR write address
- id_gpr_we_  in  1  GPR write enable, active-low
- id_exp_code  in  3  exception code
- ex_pc, ex_en, ex_br_flag, ex_mem_op, ex_mem_wr_data, ex_ctrl_op, ex_dst_addr, ex_gpr_we_, ex_exp_code, ex_out  out  30/1/1/2/32/2/5/1/3/32  EX/MEM register; ex_out is the 32-bit result

Behaviour:
- Reset (reset=0 at a clk edge):
  - All ex_* outputs = 0, except ex_gpr_we_ = 1 and ex_exp_code = NO_EXP (3'h0).
  - FSM returns to IDLE, counter = 0, busy = 0.
  - Reset overrides stall, flush and an in-progress MD op.
- ALU op encoding:
  - 0 NOP: result = in_0.
  - 1 AND, 2 OR, 3 XOR.
  - 4 ADDS, 5 ADDU, 6 SUBS, 7 SUBU.
  - 8 SHRL (in_0 >> in_1[4:0]), 9 SHLL (in_0 << in_1[4:0]).
  - 10 MULU (low 32 bits of the product), 11 DIVU, 12 REMU.
  - 13-15: treated as NOP.
- Overflow:
  - ADDS overflows when the operand signs are equal and the result sign differs.
  - SUBS overflows when the operand signs differ and the result sign differs from in_0.
  - On overflow: ex_exp_code = OVERFLOW (3'h3), ex_gpr_we_ = 1, ex_mem_op = NOP; ex_out still holds the wrapped sum.
  - An incoming id_exp_code other than NO_EXP passes through unchanged and suppresses overflow detection.
- Single-cycle ops:
  - Result is combinational.
  - Registered into EX/MEM at the clk edge when stall=0.
- FSM states IDLE, RUN, DONE:
  - IDLE→RUN: when id_en=1, op ∈ {10,11,12} and flush=0.
    - Operands latched, counter cleared.
    - busy=1 combinationally in this accept cycle.
    - EX/MEM is not loaded with this op in the accept cycle (hold when stall=1, bubble when stall=0).
  - RUN: one shift-add (MULU) or restoring-subtract (DIVU/REMU) step per cycle; busy=1.
    - The counter advances regardless of stall.
    - At counter = MD_CYCLES-1 the FSM goes to DONE.
  - DONE: busy=0; result drives fwd_data and the EX/MEM input.
    - The FSM stays in DONE while stall=1.
    - At the first edge with stall=0, EX/MEM captures the result and the FSM returns to IDLE.
    - Exactly one capture per MD op.
  - Timing: busy is high for MD_CYCLES+1 cycles (accept + RUN); the result is registered MD_CYCLES+2 edges after the accept cycle.
- Divide by zero (no exception):
  - DIVU → 0xFFFFFFFF.
  - REMU → the dividend.
- Flush:
  - At any FSM state, flush aborts to IDLE (busy=0 from the next cycle).
  - With stall=0: EX/MEM loads a bubble (ex_en=0, ex_gpr_we_=1, ex_mem_op=NOP, ex_ctrl_op=NOP, ex_exp_code=NO_EXP, other fields 0).
  - With stall=1: EX/MEM holds.
- Stall (FSM not DONE): EX/MEM holds all values.
- id_en=0: EX/MEM loads a bubble (when stall=0); no MD op starts.
- fwd_data: always the combinational next ex_out value; during RUN it is don't-care.
- Pass-through fields: pc, br_flag, mem_op, mem_wr_data, ctrl_op, dst_addr and gpr_we_ pass from id_* unchanged except as stated above. For an MD op, these fields are taken from id_* in the DONE cycle; ID is held by the stall.

Test Plan:
- ADDS 0x7FFFFFFF + 0x00000001, id_gpr_we_=0 → ex_out=0x80000000, ex_exp_code=3'h3, ex_gpr_we_=1; ADDU with the same operands → no exception.
- MULU 0x00010003 × 0x00000005 → busy high exactly 33 cycles; ex_out=0x0005000F with ex_en=1 registered 34 edges after accept; single capture.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 0x1234/0 → 0xFFFFFFFF; REMU 0x1234/0 → 0x00001234; no exception.
- Stall held for 3 cycles starting in DONE → ex_* unchanged during the stall; result captured once, on the first edge with stall=0; FSM then IDLE.
- Flush at RUN counter=10 → busy=0 next cycle, ex_en=0, ex_gpr_we_=1; the next ADDU 2+3 gives ex_out=5 in a single cycle.
- reset=0 mid-RUN, then release → all outputs at their reset values, busy=0, FSM IDLE; the next MULU 3×4 gives 12.

Source files
------------

// File: rtl/ex_md_stage.sv
// ex_md_stage: EX stage with single-cycle ALU, iterative multiply/divide unit and EX/MEM register
module ex_md_stage #(
   parameter int MD_CYCLES = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   output logic        busy,
   output logic [31:0] fwd_data,
   input  logic [29:0] id_pc,
   input  logic        id_en,
   input  logic [3:0]  id_alu_op,
   input  logic [31:0] id_alu_in_0,
   input  logic [31:0] id_alu_in_1,
   input  logic        id_br_flag,
   input  logic [1:0]  id_mem_op,
   input  logic [31:0] id_mem_wr_data,
   input  logic [1:0]  id_ctrl_op,
   input  logic [4:0]  id_dst_addr,
   input  logic        id_gpr_we_,
   input  logic [2:0]  id_exp_code,
   output logic [29:0] ex_pc,
   output logic        ex_en,
   output logic        ex_br_flag,
   output logic [1:0]  ex_mem_op,
   output logic [31:0] ex_mem_wr_data,
   output logic [1:0]  ex_ctrl_op,
   output logic [4:0]  ex_dst_addr,
   output logic        ex_gpr_we_,
   output logic [2:0]  ex_exp_code,
   output logic [31:0] ex_out
);
   localparam int CW = $clog2(MD_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(MD_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   typedef enum logic [1:0] {MD_MUL, MD_DIV, MD_REM} md_t;

   state_t        st_q;
   md_t           mop_q, mop_d;
   logic [CW-1:0] cnt_q;
   logic [31:0]   x_q, y_q, acc_q;
   logic [31:0]   alu_res, md_res, res, mul_sum, rem_sub;
   logic [32:0]   rem_sh;
   logic          is_md, start, ovf, ovf_e, rem_ge, valid;

   logic [29:0]   ex_pc_q, ex_pc_d;
   logic          ex_en_q, ex_en_d;
   logic          ex_br_q, ex_br_d;
   logic [1:0]    ex_mem_op_q, ex_mem_op_d;
   logic [31:0]   ex_wr_q, ex_wr_d;
   logic [1:0]    ex_ctrl_q, ex_ctrl_d;
   logic [4:0]    ex_dst_q, ex_dst_d;
   logic          ex_we_q, ex_we_d;
   logic [2:0]    ex_exp_q, ex_exp_d;
   logic [31:0]   ex_out_q, ex_out_d;

   // single-cycle ALU result and signed overflow flag
   always_comb begin
      ovf = 1'b0;
      alu_res = id_alu_in_0;
      case (id_alu_op)
         4'd1: alu_res = id_alu_in_0 & id_alu_in_1;
         4'd2: alu_res = id_alu_in_0 | id_alu_in_1;
         4'd3: alu_res = id_alu_in_0 ^ id_alu_in_1;
         4'd4: begin
            alu_res = id_alu_in_0 + id_alu_in_1;
            ovf = (id_alu_in_0[31] == id_alu_in_1[31]) && (alu_res[31] != id_alu_in_0[31]);
         end
         4'd5: alu_res = id_alu_in_0 + id_alu_in_1;
         4'd6: begin
            alu_res = id_alu_in_0 - id_alu_in_1;
            ovf = (id_alu_in_0[31] != id_alu_in_1[31]) && (alu_res[31] != id_alu_in_0[31]);
         end
         4'd7: alu_res = id_alu_in_0 - id_alu_in_1;
         4'd8: alu_res = id_alu_in_0 >> id_alu_in_1[4:0];
         4'd9: alu_res = id_alu_in_0 << id_alu_in_1[4:0];
         default: alu_res = id_alu_in_0;
      endcase
   end

   assign is_md = (id_alu_op == 4'd10) || (id_alu_op == 4'd11) || (id_alu_op == 4'd12);
   assign mop_d = (id_alu_op == 4'd10) ? MD_MUL : (id_alu_op == 4'd11) ? MD_DIV : MD_REM;
   assign start = reset && !flush && (st_q == IDLE) && id_en && is_md;
   assign busy  = start || (st_q == RUN);

   // one shift-add step for multiply; one restoring step for divide, quotient shifts into x_q
   assign mul_sum = acc_q + (y_q[0] ? x_q : 32'd0);
   assign rem_sh  = {acc_q, x_q[31]};
   assign rem_ge  = rem_sh >= {1'b0, y_q};
   assign rem_sub = rem_sh[31:0] - y_q;
   assign md_res  = (mop_q == MD_DIV) ? x_q : acc_q;

   assign res      = (st_q == DONE) ? md_res : alu_res;
   assign fwd_data = res;
   assign ovf_e    = ovf && (st_q != DONE) && (id_exp_code == 3'h0);
   assign valid    = !flush && id_en && ((st_q == DONE) || ((st_q == IDLE) && !is_md));

   // next EX/MEM contents: the instruction when it is ready to retire, otherwise a bubble
   always_comb begin
      ex_en_d     = valid;
      ex_pc_d     = valid ? id_pc : 30'd0;
      ex_br_d     = valid && id_br_flag;
      ex_mem_op_d = (valid && !ovf_e) ? id_mem_op : 2'd0;
      ex_wr_d     = valid ? id_mem_wr_data : 32'd0;
      ex_ctrl_d   = valid ? id_ctrl_op : 2'd0;
      ex_dst_d    = valid ? id_dst_addr : 5'd0;
      ex_we_d     = valid ? (id_gpr_we_ | ovf_e) : 1'b1;
      ex_exp_d    = !valid ? 3'h0 : ovf_e ? 3'h3 : id_exp_code;
      ex_out_d    = valid ? res : 32'd0;
   end

   // multiply/divide sequencer: accept, iterate MD_CYCLES steps, hold result until retired
   always_ff @(posedge clk) begin
      if (!reset) begin
         st_q  <= IDLE;
         cnt_q <= '0;
         mop_q <= MD_MUL;
         x_q   <= '0;
         y_q   <= '0;
         acc_q <= '0;
      end else if (flush) begin
         st_q <= IDLE;
      end else if (start) begin
         st_q  <= RUN;
         cnt_q <= '0;
         mop_q <= mop_d;
         x_q   <= id_alu_in_0;
         y_q   <= id_alu_in_1;
         acc_q <= '0;
      end else if (st_q == RUN) begin
         cnt_q <= cnt_q + CW'(1);
         if (cnt_q == LAST) st_q <= DONE;
         if (mop_q == MD_MUL) begin
            acc_q <= mul_sum;
            x_q   <= {x_q[30:0], 1'b0};
            y_q   <= {1'b0, y_q[31:1]};
         end else begin
            acc_q <= rem_ge ? rem_sub : rem_sh[31:0];
            x_q   <= {x_q[30:0], rem_ge};
         end
      end else if ((st_q == DONE) && !stall) begin
         st_q <= IDLE;
      end
   end

   // EX/MEM pipeline register, held while the controller stalls
   always_ff @(posedge clk) begin
      if (!reset) begin
         ex_pc_q     <= '0;
         ex_en_q     <= 1'b0;
         ex_br_q     <= 1'b0;
         ex_mem_op_q <= 2'd0;
         ex_wr_q     <= '0;
         ex_ctrl_q   <= 2'd0;
         ex_dst_q    <= '0;
         ex_we_q     <= 1'b1;
         ex_exp_q    <= 3'h0;
         ex_out_q    <= '0;
      end else if (!stall) begin
         ex_pc_q     <= ex_pc_d;
         ex_en_q     <= ex_en_d;
         ex_br_q     <= ex_br_d;
         ex_mem_op_q <= ex_mem_op_d;
         ex_wr_q     <= ex_wr_d;
         ex_ctrl_q   <= ex_ctrl_d;
         ex_dst_q    <= ex_dst_d;
         ex_we_q     <= ex_we_d;
         ex_exp_q    <= ex_exp_d;
         ex_out_q    <= ex_out_d;
      end
   end

   assign ex_pc          = ex_pc_q;
   assign ex_en          = ex_en_q;
   assign ex_br_flag     = ex_br_q;
   assign ex_mem_op      = ex_mem_op_q;
   assign ex_mem_wr_data = ex_wr_q;
   assign ex_ctrl_op     = ex_ctrl_q;
   assign ex_dst_addr    = ex_dst_q;
   assign ex_gpr_we_     = ex_we_q;
   assign ex_exp_code    = ex_exp_q;
   assign ex_out         = ex_out_q;
endmodule
